// File: rtl/lsu_align_unit.sv
// lsu_align_unit: load/store alignment unit between the MEM stage and the data bus.
// Accepts one access at a time, lane-shifts store data and byte enables, splits
// accesses that cross a bus word into two beats, and extends load data.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   req_valid/req_ready   access handshake from the pipeline
//   req_store, req_fun3   access kind and RISC-V funct3 width/sign encoding
//   req_addr, req_wdata   byte address, LSB-aligned store data
//   stall                 busy indication back to the pipeline
//   rsp_valid/rdata/err   one-cycle completion pulse with held result
//   mem_*                 data-memory bus (req held until ack)
module lsu_align_unit #(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_fun3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN/8-1:0] mem_mask,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [OW-1:0]     off_q;
    logic [3:0]        size_q;
    logic              split_q;
    logic              store_q;
    logic              sign_ext_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   lo_q;
    logic [XLEN-1:0]   rdata_q;
    logic              err_q;

    // Request decode, only meaningful while idle
    logic [3:0]    req_size;
    logic [OW-1:0] req_off;
    logic          req_split;
    logic          req_illegal;
    logic          req_reject;
    logic          accept;

    always_comb begin
        unique case (req_fun3[1:0])
            2'b00:   req_size = 4'd1;
            2'b01:   req_size = 4'd2;
            2'b10:   req_size = 4'd4;
            default: req_size = 4'd8;
        endcase
        req_off     = req_addr[OW-1:0];
        req_split   = (int'(req_off) + int'(req_size)) > NB;
        req_illegal = (req_fun3 == 3'b111)
                    || ((XLEN == 32) && ((req_fun3 == 3'b011) || (req_fun3 == 3'b110)))
                    || (req_store && req_fun3[2]);
        req_reject  = req_illegal || (req_split && !ALLOW_MISALIGN);
        accept      = (state_q == StIdle) && req_valid;
    end

    // Wide (two-word) lane mask and shifted store data
    logic [2*NB-1:0]   mask_base;
    logic [2*NB-1:0]   mask_wide;
    logic [2*XLEN-1:0] data_wide;

    always_comb begin
        mask_base = '0;
        for (int i = 0; i < NB; i++) begin
            mask_base[i] = (i < int'(size_q));
        end
        mask_wide = mask_base << off_q;
        data_wide = {{XLEN{1'b0}}, wdata_q} << {off_q, 3'b000};
    end

    // Load result: the beat completing the access supplies the missing word
    logic [XLEN-1:0] rd_lo, rd_hi, r_low, load_res;
    logic            sign_bit;

    always_comb begin
        rd_lo = mem_rdata;
        rd_hi = '0;
        if (state_q == StAcc1) begin
            rd_lo = lo_q;
            rd_hi = mem_rdata;
        end
        r_low = XLEN'({rd_hi, rd_lo} >> {off_q, 3'b000});
        sign_bit = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (int'(size_q) == i + 1) sign_bit = r_low[8*i+7];
        end
        load_res = '0;
        for (int i = 0; i < XLEN; i++) begin
            load_res[i] = (i < 8 * int'(size_q)) ? r_low[i] : (sign_ext_q & sign_bit);
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (req_valid) state_d = req_reject ? StResp : StAcc0;
            StAcc0: if (mem_ack) state_d = split_q ? StAcc1 : StResp;
            StAcc1: if (mem_ack) state_d = StResp;
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    // Access context and response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q     <= '0;
            off_q      <= '0;
            size_q     <= '0;
            split_q    <= 1'b0;
            store_q    <= 1'b0;
            sign_ext_q <= 1'b0;
            wdata_q    <= '0;
            lo_q       <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                base_q     <= {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
                off_q      <= req_off;
                size_q     <= req_size;
                split_q    <= req_split;
                store_q    <= req_store;
                sign_ext_q <= !req_fun3[2];
                wdata_q    <= req_wdata;
                if (req_reject) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
            if ((state_q == StAcc0) && mem_ack) lo_q <= mem_rdata;
            if (((state_q == StAcc0) && mem_ack && !split_q)
                || ((state_q == StAcc1) && mem_ack)) begin
                rdata_q <= store_q ? '0 : load_res;
                err_q   <= 1'b0;
            end
        end
    end

    // Bus and handshake outputs decode only from registered state, so they are
    // stable while waiting for ack and drop as soon as reset asserts.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_mask  = '0;
        mem_wdata = '0;
        unique case (state_q)
            StAcc0: begin
                mem_req   = 1'b1;
                mem_we    = store_q;
                mem_addr  = base_q;
                mem_mask  = mask_wide[NB-1:0];
                mem_wdata = data_wide[XLEN-1:0];
            end
            StAcc1: begin
                mem_req   = 1'b1;
                mem_we    = store_q;
                mem_addr  = base_q + ADDR_W'(NB);
                mem_mask  = mask_wide[2*NB-1:NB];
                mem_wdata = data_wide[2*XLEN-1:XLEN];
            end
            default: ;
        endcase
    end

    assign req_ready = (state_q == StIdle);
    assign stall     = !req_ready;
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_align_unit.sv
module tb_lsu_align_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, s_req_valid;
    logic        req_store;
    logic [2:0]  req_fun3;
    logic [31:0] req_addr, req_wdata;
    logic        mem_ack;
    logic        s_mem_ack;
    logic [31:0] mem_rdata;

    logic        req_ready, stall, rsp_valid, rsp_err, mem_req, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_mask;

    logic        s_req_ready, s_stall, s_rsp_valid, s_rsp_err, s_mem_req, s_mem_we;
    logic [31:0] s_rsp_rdata, s_mem_addr, s_mem_wdata;
    logic [3:0]  s_mem_mask;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int t_acc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_align_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_fun3(req_fun3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_mask(mem_mask),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    lsu_align_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGN(1'b0)) dut_strict (
        .clk(clk), .rst(rst),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_store(req_store),
        .req_fun3(req_fun3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(s_stall), .rsp_valid(s_rsp_valid), .rsp_rdata(s_rsp_rdata),
        .rsp_err(s_rsp_err),
        .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
        .mem_mask(s_mem_mask), .mem_wdata(s_mem_wdata), .mem_ack(s_mem_ack),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Called at a negedge; returns at the negedge of cycle T+1
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic strict);
        req_store = st;
        req_fun3  = f3;
        req_addr  = a;
        req_wdata = wd;
        if (strict) s_req_valid = 1'b1;
        else        req_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid   = 1'b0;
        s_req_valid = 1'b0;
        t_acc       = cyc - 1;
    endtask

    // One bus beat: check request, hold for 'waits' cycles, then ack
    task automatic beat(input string tag, input logic [31:0] ea, input logic [3:0] em,
                        input logic [31:0] ewd, input logic ewe, input logic [31:0] rd,
                        input int waits, input int ek);
        check({tag, "_req"}, 64'(mem_req), 64'd1);
        check({tag, "_addr"}, 64'(mem_addr), 64'(ea));
        check({tag, "_mask"}, 64'(mem_mask), 64'(em));
        check({tag, "_wdata"}, 64'(mem_wdata), 64'(ewd));
        check({tag, "_we"}, 64'(mem_we), 64'(ewe));
        check({tag, "_stall"}, 64'(stall), 64'd1);
        check({tag, "_cyc"}, 64'(cyc - t_acc), 64'(ek));
        for (int w = 0; w < waits; w++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_wait_req"}, 64'(mem_req), 64'd1);
            check({tag, "_wait_addr"}, 64'(mem_addr), 64'(ea));
            check({tag, "_wait_stall"}, 64'(stall), 64'd1);
        end
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(posedge clk);
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
    endtask

    task automatic resp(input string tag, input logic [31:0] erd, input logic eerr,
                        input int ek);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(erd));
        check({tag, "_rsp_err"}, 64'(rsp_err), 64'(eerr));
        check({tag, "_rsp_cyc"}, 64'(cyc - t_acc), 64'(ek));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_pulse_end"}, 64'(rsp_valid), 64'd0);
        check({tag, "_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_held"}, 64'(rsp_rdata), 64'(erd));
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; s_req_valid = 1'b0; req_store = 1'b0; req_fun3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; s_mem_ack = 1'b0;
        mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_mask", 64'(mem_mask), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);

        // Aligned lw
        issue(1'b0, 3'b010, 32'h100, 32'h0, 1'b0);
        beat("lw", 32'h100, 4'b1111, 32'h0, 1'b0, 32'hDEADBEEF, 0, 1);
        resp("lw", 32'hDEADBEEF, 1'b0, 2);

        // Byte and halfword loads
        issue(1'b0, 3'b000, 32'h103, 32'h0, 1'b0);
        beat("lb", 32'h100, 4'b1000, 32'h0, 1'b0, 32'h80112233, 0, 1);
        resp("lb", 32'hFFFFFF80, 1'b0, 2);
        issue(1'b0, 3'b100, 32'h103, 32'h0, 1'b0);
        beat("lbu", 32'h100, 4'b1000, 32'h0, 1'b0, 32'h80112233, 0, 1);
        resp("lbu", 32'h00000080, 1'b0, 2);
        issue(1'b0, 3'b001, 32'h102, 32'h0, 1'b0);
        beat("lh", 32'h100, 4'b1100, 32'h0, 1'b0, 32'h80112233, 0, 1);
        resp("lh", 32'hFFFF8011, 1'b0, 2);

        // Aligned sb lane shift
        issue(1'b1, 3'b000, 32'h101, 32'h000000A5, 1'b0);
        beat("sb", 32'h100, 4'b0010, 32'h0000A500, 1'b1, 32'h0, 0, 1);
        resp("sb", 32'h0, 1'b0, 2);

        // Split sw
        issue(1'b1, 3'b010, 32'h0FE, 32'hAABBCCDD, 1'b0);
        beat("sw0", 32'h0FC, 4'b1100, 32'hCCDD0000, 1'b1, 32'h0, 0, 1);
        beat("sw1", 32'h100, 4'b0011, 32'h0000AABB, 1'b1, 32'h0, 0, 2);
        resp("sw", 32'h0, 1'b0, 3);

        // Split lh with three wait cycles on the second beat
        issue(1'b0, 3'b001, 32'h0FF, 32'h0, 1'b0);
        beat("lh0", 32'h0FC, 4'b1000, 32'h0, 1'b0, 32'h34000000, 0, 1);
        beat("lh1", 32'h100, 4'b0001, 32'h0, 1'b0, 32'h00000092, 3, 2);
        resp("lhs", 32'hFFFF9234, 1'b0, 6);

        // Split lw wrapping the top of the address space
        issue(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 1'b0);
        beat("wr0", 32'hFFFFFFFC, 4'b1100, 32'h0, 1'b0, 32'h55660000, 0, 1);
        beat("wr1", 32'h00000000, 4'b0011, 32'h0, 1'b0, 32'h00007788, 0, 2);
        resp("wrap", 32'h77885566, 1'b0, 3);

        // Misaligned reject with ALLOW_MISALIGN=0
        issue(1'b0, 3'b010, 32'h102, 32'h0, 1'b1);
        check("strict_rsp_valid", 64'(s_rsp_valid), 64'd1);
        check("strict_rsp_err", 64'(s_rsp_err), 64'd1);
        check("strict_mem_req", 64'(s_mem_req), 64'd0);
        check("strict_cyc", 64'(cyc - t_acc), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("strict_pulse_end", 64'(s_rsp_valid), 64'd0);
        check("strict_ready", 64'(s_req_ready), 64'd1);
        check("strict_mem_req2", 64'(s_mem_req), 64'd0);

        // Illegal fun3 rejects
        issue(1'b0, 3'b111, 32'h100, 32'h0, 1'b0);
        check("f111_mem_req", 64'(mem_req), 64'd0);
        resp("f111", 32'h0, 1'b1, 1);
        issue(1'b1, 3'b100, 32'h100, 32'h0, 1'b0);
        check("sbu_mem_req", 64'(mem_req), 64'd0);
        resp("sbu", 32'h0, 1'b1, 1);
        issue(1'b0, 3'b011, 32'h100, 32'h0, 1'b0);
        resp("ld32", 32'h0, 1'b1, 1);

        // Reset in the middle of an access
        issue(1'b0, 3'b010, 32'h300, 32'h0, 1'b0);
        check("mid_req_before", 64'(mem_req), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_req_async", 64'(mem_req), 64'd0);
        check("mid_rsp_async", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'hBADBAD00;
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        check("mid_ready", 64'(req_ready), 64'd1);
        check("mid_stray_req", 64'(mem_req), 64'd0);
        check("mid_stray_rsp", 64'(rsp_valid), 64'd0);
        issue(1'b0, 3'b010, 32'h200, 32'h0, 1'b0);
        beat("post", 32'h200, 4'b1111, 32'h0, 1'b0, 32'h12345678, 0, 1);
        resp("post", 32'h12345678, 1'b0, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
